// File: rtl/fp_mult_pkg.sv
// Shared types and helpers for the pipelined IEEE-754 multiplier.
package fp_mult_pkg;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

  localparam int NFLAGS  = 3;
  localparam int FLG_INV = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UNF = 0;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: positive, all-ones exponent, fraction MSB only.
  function automatic logic [63:0] qnan(input int exp_w, input int frac_w);
    return (((64'd1 << exp_w) - 64'd1) << frac_w) | (64'd1 << (frac_w - 1));
  endfunction

endpackage

// File: rtl/fp_mult_if.sv
// Operand-issue / result-writeback handshake bundle for fp_mult_pipe.
interface fp_mult_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 4
);
  import fp_mult_pkg::*;

  localparam int W = 1 + EXP_W + FRAC_W;

  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_a;
  logic [W-1:0]      in_b;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_result;
  logic [TAG_W-1:0]  out_tag;
  logic [NFLAGS-1:0] out_flags;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_flags
  );

endinterface

// File: rtl/fp_mult_round.sv
// Normalise, round-to-nearest-even, range check and pack a raw significand product.
module fp_mult_round
  import fp_mult_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic [2*FRAC_W+1:0]      prod_i,
  input  logic signed [EXP_W+1:0]  exp_i,
  input  logic                     sign_i,
  output logic [EXP_W+FRAC_W:0]    result_o,
  output logic [NFLAGS-1:0]        flags_o
);
  localparam int PW  = 2 * FRAC_W + 2;
  localparam int EW2 = EXP_W + 2;
  localparam logic signed [EW2-1:0] EMAX  = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] EZERO = '0;

  logic                  msb;
  logic [PW-1:0]         norm;
  logic [FRAC_W:0]       sig;
  logic                  guard;
  logic                  sticky;
  logic                  rnd_up;
  logic [FRAC_W+1:0]     sig_r;
  logic signed [EW2-1:0] e_n;
  logic signed [EW2-1:0] e_r;
  logic [FRAC_W-1:0]     frac;

  // Left-align so the hidden bit always lands in the top position.
  assign msb    = prod_i[PW-1];
  assign norm   = msb ? prod_i : (prod_i << 1);
  assign sig    = norm[PW-1 -: FRAC_W+1];
  assign guard  = norm[FRAC_W];
  assign sticky = |norm[FRAC_W-1:0];
  assign rnd_up = guard & (sticky | sig[0]);
  assign sig_r  = {1'b0, sig} + {{(FRAC_W+1){1'b0}}, rnd_up};

  assign e_n  = exp_i + $signed({{(EW2-1){1'b0}}, msb});
  assign e_r  = e_n + $signed({{(EW2-1){1'b0}}, sig_r[FRAC_W+1]});
  assign frac = sig_r[FRAC_W+1] ? sig_r[FRAC_W:1] : sig_r[FRAC_W-1:0];

  always_comb begin
    flags_o = '0;
    if (e_r >= EMAX) begin
      result_o         = {sign_i, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      flags_o[FLG_OVF] = 1'b1;
    end else if (e_r <= EZERO) begin
      result_o         = {sign_i, {(EXP_W+FRAC_W){1'b0}}};
      flags_o[FLG_UNF] = 1'b1;
    end else begin
      result_o = {sign_i, e_r[EXP_W-1:0], frac};
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage IEEE-754 multiplier (classify / multiply / round) with a global-stall handshake.
module fp_mult_pipe
  import fp_mult_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 4
) (
  input logic      clk,
  input logic      rst,
  fp_mult_if.slave bus
);
  localparam int W   = 1 + EXP_W + FRAC_W;
  localparam int EW2 = EXP_W + 2;
  localparam int MW  = FRAC_W + 1;
  localparam int PW  = 2 * MW;
  localparam logic [W-1:0]   QNAN   = W'(qnan(EXP_W, FRAC_W));
  localparam logic [EW2-1:0] BIAS_X = EW2'(bias(EXP_W));

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
    if (e == '0) return ZERO;
    if (&e) return (f == '0) ? INF : NAN;
    return NORM;
  endfunction

  logic                  advance;
  fp_class_e             ca, cb;
  logic                  inv;
  logic                  sign_d;
  logic                  spec_d;
  logic [W-1:0]          sres_d;
  logic [NFLAGS-1:0]     sflg_d;
  logic signed [EW2-1:0] exp_d;
  logic [MW-1:0]         ma_d, mb_d;
  logic [PW-1:0]         prod_d;
  logic [W-1:0]          rnd_result;
  logic [NFLAGS-1:0]     rnd_flags;

  logic                  s1_valid_q, s1_sign_q, s1_spec_q;
  logic signed [EW2-1:0] s1_exp_q;
  logic [MW-1:0]         s1_ma_q, s1_mb_q;
  logic [W-1:0]          s1_sres_q;
  logic [NFLAGS-1:0]     s1_sflg_q;
  logic [TAG_W-1:0]      s1_tag_q;

  logic                  s2_valid_q, s2_sign_q, s2_spec_q;
  logic signed [EW2-1:0] s2_exp_q;
  logic [PW-1:0]         s2_prod_q;
  logic [W-1:0]          s2_sres_q;
  logic [NFLAGS-1:0]     s2_sflg_q;
  logic [TAG_W-1:0]      s2_tag_q;

  logic                  out_valid_q;
  logic [W-1:0]          out_result_q;
  logic [NFLAGS-1:0]     out_flags_q;
  logic [TAG_W-1:0]      out_tag_q;

  assign advance = !out_valid_q || bus.out_ready;

  assign ca     = classify(bus.in_a[W-2 -: EXP_W], bus.in_a[FRAC_W-1:0]);
  assign cb     = classify(bus.in_b[W-2 -: EXP_W], bus.in_b[FRAC_W-1:0]);
  assign inv    = (ca == INF && cb == ZERO) || (ca == ZERO && cb == INF);
  assign sign_d = bus.in_a[W-1] ^ bus.in_b[W-1];
  assign ma_d   = {1'b1, bus.in_a[FRAC_W-1:0]};
  assign mb_d   = {1'b1, bus.in_b[FRAC_W-1:0]};
  assign exp_d  = $signed({2'b00, bus.in_a[W-2 -: EXP_W]})
                + $signed({2'b00, bus.in_b[W-2 -: EXP_W]}) - $signed(BIAS_X);
  assign prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);

  // Special operands bypass the arithmetic; the result is fixed here in S1.
  always_comb begin
    spec_d = 1'b1;
    sres_d = '0;
    sflg_d = '0;
    if (inv || ca == NAN || cb == NAN) begin
      sres_d          = QNAN;
      sflg_d[FLG_INV] = inv;
    end else if (ca == INF || cb == INF) begin
      sres_d = {sign_d, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (ca == ZERO || cb == ZERO) begin
      sres_d = {sign_d, {(W-1){1'b0}}};
    end else begin
      spec_d = 1'b0;
    end
  end

  fp_mult_round #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_round (
    .prod_i   (s2_prod_q),
    .exp_i    (s2_exp_q),
    .sign_i   (s2_sign_q),
    .result_o (rnd_result),
    .flags_o  (rnd_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_spec_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_ma_q      <= '0;
      s1_mb_q      <= '0;
      s1_sres_q    <= '0;
      s1_sflg_q    <= '0;
      s1_tag_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_sign_q    <= 1'b0;
      s2_spec_q    <= 1'b0;
      s2_exp_q     <= '0;
      s2_prod_q    <= '0;
      s2_sres_q    <= '0;
      s2_sflg_q    <= '0;
      s2_tag_q     <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
      out_tag_q    <= '0;
    end else if (advance) begin
      s1_valid_q   <= bus.in_valid;
      s1_sign_q    <= sign_d;
      s1_spec_q    <= spec_d;
      s1_exp_q     <= exp_d;
      s1_ma_q      <= ma_d;
      s1_mb_q      <= mb_d;
      s1_sres_q    <= sres_d;
      s1_sflg_q    <= sflg_d;
      s1_tag_q     <= bus.in_tag;
      s2_valid_q   <= s1_valid_q;
      s2_sign_q    <= s1_sign_q;
      s2_spec_q    <= s1_spec_q;
      s2_exp_q     <= s1_exp_q;
      s2_prod_q    <= prod_d;
      s2_sres_q    <= s1_sres_q;
      s2_sflg_q    <= s1_sflg_q;
      s2_tag_q     <= s1_tag_q;
      out_valid_q  <= s2_valid_q;
      out_result_q <= s2_spec_q ? s2_sres_q : rnd_result;
      out_flags_q  <= s2_spec_q ? s2_sflg_q : rnd_flags;
      out_tag_q    <= s2_tag_q;
    end
  end

  assign bus.in_ready   = advance;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_flags  = out_flags_q;
  assign bus.out_tag    = out_tag_q;

endmodule
